// File: rtl/cfg_chain_reader_pkg.sv
// Shared types and sizing helpers for the configuration-chain readback engine.
package cfg_chain_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of output words needed to cover the whole chain.
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bit count carried by the final (possibly partial) word.
  function automatic int unsigned rem_bits(input int unsigned chain_len,
                                           input int unsigned word_w);
    return chain_len - (num_words(chain_len, word_w) - 1) * word_w;
  endfunction

  // Counter width able to hold 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cfg_chain_packer.sv
// Serial-to-parallel word assembler: one bit per enabled cycle at a given index,
// with a combinational view that merges the in-flight bit and zeroes unused MSBs.
module cfg_chain_packer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              clr,
  input  logic              bit_en,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic [IDX_W-1:0]  nbits,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_c
);

  logic [WORD_W-1:0] bits_q;

  // Clear wins over capture so the word that just completed starts the next one empty.
  always_ff @(posedge CK) begin
    if (RST || clr) begin
      bits_q <= '0;
    end else if (bit_en) begin
      for (int unsigned i = 0; i < WORD_W; i++) begin
        if (IDX_W'(i) == bit_idx) bits_q[i] <= bit_in;
      end
    end
  end

  always_comb begin
    word_c = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (IDX_W'(i) < nbits) begin
        word_c[i] = (bit_en && (IDX_W'(i) == bit_idx)) ? bit_in : bits_q[i];
      end
    end
  end

endmodule

// File: rtl/cfg_chain_reader.sv
// Reads a serial configuration chain out through its tail flop, packs the bits
// LSB-first into words and streams them on a valid/ready port.
module cfg_chain_reader
  import cfg_chain_reader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned RESTORE   = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              chain_q,
  output logic              chain_d,
  output logic              chain_shift_en,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int unsigned REM    = rem_bits(CHAIN_LEN, WORD_W);
  localparam int unsigned BIT_W  = cnt_width(WORD_W);
  localparam int unsigned WIDX_W = cnt_width(NWORDS);

  state_e            state, state_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
  logic [WIDX_W-1:0] word_idx, word_idx_nxt;
  logic [WORD_W-1:0] m_data_nxt;
  logic              m_valid_nxt, m_last_nxt, busy_nxt, done_nxt;

  logic              last_word_c;
  logic [BIT_W-1:0]  word_len_c;
  logic              pk_clr_c, pk_en_c;
  logic [WORD_W-1:0] pk_word_c;

  assign last_word_c    = (word_idx == WIDX_W'(NWORDS - 1));
  assign word_len_c     = last_word_c ? BIT_W'(REM) : BIT_W'(WORD_W);
  assign chain_shift_en = (state == SHIFT);
  // Loopback keeps the chain intact across a full rotation; otherwise zeros fill it.
  assign chain_d        = (RESTORE != 0) ? chain_q : 1'b0;

  cfg_chain_packer #(
    .WORD_W (WORD_W),
    .IDX_W  (BIT_W)
  ) u_packer (
    .CK      (CK),
    .RST     (RST),
    .clr     (pk_clr_c),
    .bit_en  (pk_en_c),
    .bit_idx (bit_idx),
    .nbits   (word_len_c),
    .bit_in  (chain_q),
    .word_c  (pk_word_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    word_idx_nxt = word_idx;
    m_data_nxt   = m_data;
    m_valid_nxt  = m_valid;
    m_last_nxt   = m_last;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    pk_clr_c     = 1'b0;
    pk_en_c      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SHIFT;
          busy_nxt     = 1'b1;
          pk_clr_c     = 1'b1;
          bit_idx_nxt  = '0;
          word_idx_nxt = '0;
        end
      end
      SHIFT: begin
        pk_en_c = 1'b1;
        if (bit_idx == word_len_c - BIT_W'(1)) begin
          m_data_nxt  = pk_word_c;
          m_valid_nxt = 1'b1;
          m_last_nxt  = last_word_c;
          pk_clr_c    = 1'b1;
          bit_idx_nxt = '0;
          state_nxt   = PUSH;
        end else begin
          bit_idx_nxt = bit_idx + BIT_W'(1);
        end
      end
      PUSH: begin
        if (m_ready) begin
          m_valid_nxt = 1'b0;
          m_last_nxt  = 1'b0;
          if (m_last) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            word_idx_nxt = word_idx + WIDX_W'(1);
            state_nxt    = SHIFT;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= IDLE;
      bit_idx  <= '0;
      word_idx <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_idx  <= bit_idx_nxt;
      word_idx <= word_idx_nxt;
      m_data   <= m_data_nxt;
      m_valid  <= m_valid_nxt;
      m_last   <= m_last_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cfg_chain_reader.sv
// Bench for cfg_chain_reader: three configurations driven against a word-level
// reference model that snapshots the chain at start and predicts the stream timing.
module tb_cfg_chain_reader;

  localparam int NI = 3;
  localparam int WW = 8;

  int len_a [NI] = '{20, 8, 1};
  int res_a [NI] = '{1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          rst, start, m_ready, chain_q, chain_d, shift_en;
  logic [NI-1:0]          m_valid, m_last, busy, done, pre_req;
  logic [NI-1:0][WW-1:0]  m_data;
  logic [NI-1:0][63:0]    chain, pre_val;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  cfg_chain_reader #(.CHAIN_LEN(20), .WORD_W(8), .RESTORE(1)) u_a (
    .CK(clk), .RST(rst[0]), .start(start[0]), .chain_q(chain_q[0]), .chain_d(chain_d[0]),
    .chain_shift_en(shift_en[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_last(m_last[0]), .busy(busy[0]), .done(done[0]));

  cfg_chain_reader #(.CHAIN_LEN(8), .WORD_W(8), .RESTORE(0)) u_b (
    .CK(clk), .RST(rst[1]), .start(start[1]), .chain_q(chain_q[1]), .chain_d(chain_d[1]),
    .chain_shift_en(shift_en[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_last(m_last[1]), .busy(busy[1]), .done(done[1]));

  cfg_chain_reader #(.CHAIN_LEN(1), .WORD_W(8), .RESTORE(1)) u_c (
    .CK(clk), .RST(rst[2]), .start(start[2]), .chain_q(chain_q[2]), .chain_d(chain_d[2]),
    .chain_shift_en(shift_en[2]), .m_data(m_data[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready[2]), .m_last(m_last[2]), .busy(busy[2]), .done(done[2]));

  // Chain flops: bit 0 is the head, bit len-1 the tail.
  assign chain_q[0] = chain[0][19];
  assign chain_q[1] = chain[1][7];
  assign chain_q[2] = chain[2][0];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (pre_req[i])       chain[i] <= pre_val[i];
      else if (shift_en[i]) chain[i] <= {chain[i][62:0], chain_d[i]};
    end
  end

  function automatic int nw_of(input int i);
    return (len_a[i] + WW - 1) / WW;
  endfunction

  function automatic int wlen_of(input int i, input int w);
    return (w == nw_of(i) - 1) ? len_a[i] - (nw_of(i) - 1) * WW : WW;
  endfunction

  // Place value bit k so that it is the k-th bit to leave the tail.
  function automatic logic [63:0] seq_to_chain(input int L, input logic [63:0] v);
    logic [63:0] c;
    c = '0;
    for (int k = 0; k < L; k++) c[L-1-k] = v[k];
    return c;
  endfunction

  // Reference model state and observation logs.
  int md_act [NI], md_sleft [NI], md_valid [NI], md_last [NI], md_data [NI];
  int md_done [NI], md_widx [NI];
  int md_words [NI][8];
  int n_shift [NI], n_done [NI], wcnt [NI];
  int wlog [NI][256];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int pd;
      if (shift_en[i]) n_shift[i]++;
      if (done[i] === 1'b1) n_done[i]++;
      if (m_valid[i] === 1'b1 && m_ready[i] && wcnt[i] < 256) begin
        wlog[i][wcnt[i]] = 32'(m_data[i]);
        wcnt[i]++;
      end
      pd = md_done[i];
      md_done[i] = 0;
      if (rst[i]) begin
        md_act[i] = 0; md_sleft[i] = 0; md_valid[i] = 0; md_last[i] = 0;
        md_data[i] = 0; md_widx[i] = 0;
      end else if (md_act[i] == 0 && pd == 0 && start[i]) begin
        for (int w = 0; w < 8; w++) md_words[i][w] = 0;
        for (int k = 0; k < len_a[i]; k++)
          md_words[i][k/WW] = md_words[i][k/WW] | (int'(chain[i][len_a[i]-1-k]) << (k % WW));
        md_act[i] = 1; md_widx[i] = 0; md_sleft[i] = wlen_of(i, 0);
      end else if (md_sleft[i] > 0) begin
        md_sleft[i]--;
        if (md_sleft[i] == 0) begin
          md_valid[i] = 1;
          md_data[i]  = md_words[i][md_widx[i]];
          md_last[i]  = (md_widx[i] == nw_of(i) - 1) ? 1 : 0;
        end
      end else if (md_valid[i] == 1 && m_ready[i]) begin
        md_valid[i] = 0;
        if (md_last[i] == 1) begin
          md_last[i] = 0; md_act[i] = 0; md_done[i] = 1;
        end else begin
          md_widx[i]++;
          md_sleft[i] = wlen_of(i, md_widx[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("busy%0d", i),     32'(busy[i]),     32'(md_act[i]));
        chk($sformatf("done%0d", i),     32'(done[i]),     32'(md_done[i]));
        chk($sformatf("m_valid%0d", i),  32'(m_valid[i]),  32'(md_valid[i]));
        chk($sformatf("m_last%0d", i),   32'(m_last[i]),   32'(md_last[i]));
        chk($sformatf("shift_en%0d", i), 32'(shift_en[i]), (md_sleft[i] > 0) ? 32'd1 : 32'd0);
        chk($sformatf("chain_d%0d", i),  32'(chain_d[i]),  (res_a[i] != 0) ? 32'(chain_q[i]) : 32'd0);
        if (md_valid[i] == 1) chk($sformatf("m_data%0d", i), 32'(m_data[i]), 32'(md_data[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic preload(input int i, input logic [63:0] v);
    pre_val[i] = v;
    pre_req[i] = 1'b1;
    @(negedge clk);
    pre_req[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input bit rnd);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      if (rnd) begin
        m_ready[i] = ($urandom_range(0, 3) != 0);
        start[i]   = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      n++;
    end
    start[i]   = 1'b0;
    m_ready[i] = 1'b1;
    chk($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
  endtask

  initial begin
    logic [63:0] v, rot;
    int bw, bs, bd, n;

    rst = '1; start = '0; m_ready = '1; pre_req = '1; pre_val = '0;
    cyc(3);
    rst = '0; pre_req = '0;
    chk_en = 1'b1;
    chk("rst_m_data", 32'(m_data[0]), 32'd0);
    chk("rst_busy",   32'(busy[0]),   32'd0);
    chk("rst_valid",  32'(m_valid[0]), 32'd0);

    // Nominal 3-word readback with loopback.
    v = seq_to_chain(20, 64'h93CA5);
    preload(0, v);
    bw = wcnt[0]; bs = n_shift[0]; bd = n_done[0];
    pulse_start(0);
    wait_done(0, 200, 1'b0);
    cyc(2);
    chk("t1_word0", 32'(wlog[0][bw]),   32'hA5);
    chk("t1_word1", 32'(wlog[0][bw+1]), 32'h3C);
    chk("t1_word2", 32'(wlog[0][bw+2]), 32'h09);
    chk("t1_nwords", 32'(wcnt[0] - bw), 32'd3);
    chk("t1_shifts", 32'(n_shift[0] - bs), 32'd20);
    chk("t1_dones",  32'(n_done[0] - bd), 32'd1);
    chk("t1_chain",  32'(chain[0][19:0]), 32'(v[19:0]));

    // Backpressure on the second word.
    bw = wcnt[0]; bs = n_shift[0];
    pulse_start(0);
    n = 0;
    while (wcnt[0] - bw < 1 && n < 100) begin cyc(1); n++; end
    m_ready[0] = 1'b0;
    n = 0;
    while (m_valid[0] !== 1'b1 && n < 100) begin cyc(1); n++; end
    chk("t2_stall_valid", 32'(m_valid[0]), 32'd1);
    cyc(5);
    chk("t2_stall_data", 32'(m_data[0]), 32'h3C);
    m_ready[0] = 1'b1;
    wait_done(0, 200, 1'b0);
    cyc(2);
    chk("t2_word1",  32'(wlog[0][bw+1]), 32'h3C);
    chk("t2_shifts", 32'(n_shift[0] - bs), 32'd20);

    // Reset during the 10th shift cycle, then a full readback of the rotated chain.
    bs = n_shift[0];
    pulse_start(0);
    n = 0;
    while (!(n_shift[0] - bs == 9 && shift_en[0] === 1'b1) && n < 100) begin cyc(1); n++; end
    rst[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0;
    chk("t3_busy",  32'(busy[0]),     32'd0);
    chk("t3_valid", 32'(m_valid[0]),  32'd0);
    chk("t3_data",  32'(m_data[0]),   32'd0);
    chk("t3_shift", 32'(shift_en[0]), 32'd0);
    chk("t3_nshift", 32'(n_shift[0] - bs), 32'd10);
    rot = '0;
    for (int j = 0; j < 20; j++) rot[j] = v[(j - 10 + 20) % 20];
    chk("t3_rotated", 32'(chain[0][19:0]), 32'(rot[19:0]));
    bw = wcnt[0]; bd = n_done[0];
    pulse_start(0);
    wait_done(0, 200, 1'b0);
    cyc(2);
    chk("t3_nwords", 32'(wcnt[0] - bw), 32'd3);
    chk("t3_dones",  32'(n_done[0] - bd), 32'd1);
    chk("t3_chain",  32'(chain[0][19:0]), 32'(rot[19:0]));

    // Start pulses during PUSH and during DONE must be ignored.
    bw = wcnt[0]; bd = n_done[0];
    m_ready[0] = 1'b0;
    pulse_start(0);
    n = 0;
    while (m_valid[0] !== 1'b1 && n < 100) begin cyc(1); n++; end
    pulse_start(0);
    m_ready[0] = 1'b1;
    n = 0;
    while (done[0] !== 1'b1 && n < 200) begin cyc(1); n++; end
    pulse_start(0);
    cyc(3);
    chk("t4_busy",   32'(busy[0]), 32'd0);
    chk("t4_dones",  32'(n_done[0] - bd), 32'd1);
    chk("t4_nwords", 32'(wcnt[0] - bw), 32'd3);

    // Destructive read: ones come out once, zeros afterwards.
    preload(1, 64'hFF);
    bw = wcnt[1];
    pulse_start(1);
    wait_done(1, 100, 1'b0);
    cyc(1);
    chk("t5_word",  32'(wlog[1][bw]), 32'hFF);
    chk("t5_chain", 32'(chain[1][7:0]), 32'h00);
    pulse_start(1);
    wait_done(1, 100, 1'b0);
    cyc(1);
    chk("t5_word2", 32'(wlog[1][bw+1]), 32'h00);

    // Single-bit chain.
    preload(2, 64'h1);
    bs = n_shift[2];
    pulse_start(2);
    cyc(1);
    chk("t6_valid", 32'(m_valid[2]), 32'd1);
    chk("t6_data",  32'(m_data[2]),  32'h01);
    chk("t6_last",  32'(m_last[2]),  32'd1);
    cyc(1);
    chk("t6_done",  32'(done[2]), 32'd1);
    chk("t6_nshift", 32'(n_shift[2] - bs), 32'd1);

    // Randomized contents, backpressure and stray start pulses.
    for (int it = 0; it < 12; it++) begin
      v = {44'd0, 20'($urandom)};
      preload(0, v);
      pulse_start(0);
      wait_done(0, 400, 1'b1);
      cyc(2);
      chk("rnd_chain0", 32'(chain[0][19:0]), 32'(v[19:0]));
      preload(1, {56'd0, 8'($urandom)});
      pulse_start(1);
      wait_done(1, 200, 1'b1);
      cyc(2);
      chk("rnd_chain1", 32'(chain[1][7:0]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_chain_reader.md
Name: cfg_chain_reader

Overview:
Readback engine for a serial configuration chain built from clocked set/reset flip-flops. It shifts the chain's tail bit out one bit per cycle and packs the bits into WORD_W-bit words, which it delivers on a valid/ready stream. With RESTORE=1 the tail bit is fed back into the chain head, so chain contents are unchanged after a full readback. It sits beside the configuration chain writer and shares the chain's clock.

Parameters:
CHAIN_LEN, 64, number of flops in the chain (>=1)
WORD_W, 8, bits per output word (>=1)
RESTORE, 1, 1: chain_d = chain_q (loopback); 0: chain_d = 0 (destructive read)

Ports:
CK  input  1  clock shared with chain flops
RST  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin readback; ignored unless IDLE
chain_q  input  1  tail-flop output of chain
chain_d  output  1  value driven into chain head
chain_shift_en  output  1  chain shift enable; chain advances at the posedge where this is 1
m_data  output  WORD_W  packed readback word
m_valid  output  1  m_data valid
m_ready  input  1  consumer accepts when m_valid && m_ready at posedge
m_last  output  1  qualifies final word
busy  output  1  readback in progress
done  output  1  one-cycle pulse after last word is accepted

Behaviour:
- NWORDS = ceil(CHAIN_LEN/WORD_W). REM = CHAIN_LEN - (NWORDS-1)*WORD_W is the bit count of the last word.
- States: IDLE, SHIFT, PUSH, DONE.
- Reset (RST=1 at posedge): state=IDLE; m_data=0, m_valid=0, m_last=0, busy=0, done=0; bit and word counters=0. Reset mid-readback aborts immediately. chain_shift_en is 0 from the next cycle, and the chain is left partially rotated. This is acceptable and not recovered.
- chain_shift_en = (state==SHIFT), combinational from state. chain_d = RESTORE ? chain_q : 0, combinational.
- IDLE: on start, go to SHIFT, set busy=1, clear the packer, word_idx=0.
- SHIFT: at each posedge, capture chain_q into packer bit position bit_idx (first captured bit goes to LSB). The chain shifts on the same edge.
  - bit_idx counts 0..WORD_W-1, or 0..REM-1 for the last word.
  - After the final bit of the word: load m_data, pad unused MSBs of the last word with 0, set m_valid=1, set m_last=(word_idx==NWORDS-1), go to PUSH.
- PUSH: hold m_data and m_last stable while m_valid && !m_ready. chain_shift_en=0 (the chain stalls).
  - On handshake: m_valid=0. If m_last, go to DONE. Otherwise word_idx+1 and return to SHIFT.
- DONE: done=1 for exactly one cycle, busy=0, m_last=0, then IDLE.
- Latency: first m_valid asserts WORD_W cycles after the start cycle (min(WORD_W,CHAIN_LEN) if single word). Exactly CHAIN_LEN shift cycles per readback.
- start asserted in SHIFT, PUSH or DONE is ignored with no queuing. start in the same cycle as RST is ignored.
- m_ready while m_valid=0 has no effect.
- Counters: bit_idx is $clog2(WORD_W+1) bits wide and word_idx is $clog2(NWORDS+1) bits wide. Neither wraps within one readback.

Decomposition:
- Package cfg_chain_reader_pkg: state enum (IDLE, SHIFT, PUSH, DONE); NWORDS/REM constant functions; counter width functions.
- Sub-module cfg_chain_packer: serial-to-parallel register with clear, bit-enable, index and zero-padding.
- Top holds the FSM, counters and the stream register.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, RESTORE=1, chain preloaded so the tail-first bit sequence is 0xA5, 0x3C, 0x9 (LSB-first), m_ready=1 -> words 0xA5, 0x3C, 0x09. m_last only on the third word. done pulses once. Exactly 20 chain_shift_en cycles. Chain contents identical to the preload afterward.
- Same setup, m_ready held 0 for 5 cycles on word 2 -> m_data=0x3C stable throughout, chain_shift_en=0 during the stall, total shift cycles still 20.
- RESTORE=0, CHAIN_LEN=8, WORD_W=8, chain=0xFF -> single word 0xFF with m_last=1, then chain reads all 0 on a second readback (word 0x00).
- RST asserted on the 10th cycle of SHIFT -> next cycle all outputs 0, state IDLE. A new start then produces a full 3-word readback.
- start pulsed during PUSH and again during DONE -> ignored: a single readback occurs, one done pulse.
- CHAIN_LEN=1, WORD_W=8, tail=1 -> one SHIFT cycle, m_data=0x01, m_last=1, done one cycle after the handshake.
